// File: rtl/stack_cpu_core.sv
// ---------------------------------------------------------------------------
// stack_cpu_core
//
// Parametrised 8-bit-opcode stack CPU. It fetches from an external synchronous
// code ROM with one cycle of read latency. It executes one-byte instructions
// in 2 cycles and two-byte relative branches/calls in 4 cycles. Stack
// overflow/underflow and illegal opcodes are trapped into a halted fault state.
//
// Optional feature: define STACK_CPU_MUL_EN to enable opcode 0x25 (MUL).
// Without it, 0x25 is an illegal opcode (fault_code 5).
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high
//   run          1 = allow the FETCH -> EXEC transition, 0 = stall in FETCH
//   code_addr    ROM read address (the program counter)
//   code_data    ROM data, valid the cycle after code_addr is presented
//   print_valid  one-cycle pulse following an executed PRINT
//   print_s1     second-of-stack captured by PRINT
//   print_s0     top-of-stack captured by PRINT
//   halted       core stopped (HALT opcode or fault)
//   fault        core stopped because of a fault
//   fault_code   0 none, 1 dstack ovf, 2 dstack unf, 3 cstack ovf,
//                4 cstack unf, 5 illegal opcode
//   depth        current data stack occupancy
// ---------------------------------------------------------------------------
module stack_cpu_core #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 12,
   parameter int DSTACK_DEPTH = 8,
   parameter int CSTACK_DEPTH = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          run,
   output logic [ADDR_W-1:0]             code_addr,
   input  logic [7:0]                    code_data,
   output logic                          print_valid,
   output logic [DATA_W-1:0]             print_s1,
   output logic [DATA_W-1:0]             print_s0,
   output logic                          halted,
   output logic                          fault,
   output logic [2:0]                    fault_code,
   output logic [$clog2(DSTACK_DEPTH):0] depth
);

   localparam int DPW = $clog2(DSTACK_DEPTH);
   localparam int DCW = DPW + 1;
   localparam int CPW = $clog2(CSTACK_DEPTH);
   localparam int CCW = CPW + 1;

   localparam logic [DCW-1:0] DFULL = DCW'(DSTACK_DEPTH);
   localparam logic [CCW-1:0] CFULL = CCW'(CSTACK_DEPTH);

`ifdef STACK_CPU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_ADD   = 8'h20;
   localparam logic [7:0] OP_SUB   = 8'h21;
   localparam logic [7:0] OP_AND   = 8'h22;
   localparam logic [7:0] OP_OR    = 8'h23;
   localparam logic [7:0] OP_DUP   = 8'h24;
   localparam logic [7:0] OP_MUL   = 8'h25;
   localparam logic [7:0] OP_DROP  = 8'h26;
   localparam logic [7:0] OP_JMP   = 8'h30;
   localparam logic [7:0] OP_JZ    = 8'h31;
   localparam logic [7:0] OP_CALL  = 8'h32;
   localparam logic [7:0] OP_RET   = 8'h33;
   localparam logic [7:0] OP_PRINT = 8'h41;
   localparam logic [7:0] OP_HALT  = 8'h44;

   localparam logic [2:0] F_NONE  = 3'd0;
   localparam logic [2:0] F_DOVF  = 3'd1;
   localparam logic [2:0] F_DUNF  = 3'd2;
   localparam logic [2:0] F_COVF  = 3'd3;
   localparam logic [2:0] F_CUNF  = 3'd4;
   localparam logic [2:0] F_ILL   = 3'd5;

   typedef enum logic [2:0] {
      S_FETCH,
      S_EXEC,
      S_FETCH2,
      S_EXEC2,
      S_HALT
   } state_t;

   // Two-operand ALU; a is S1, b is S0 (SUB computes S1 - S0).
   function automatic logic [DATA_W-1:0] alu(input logic [7:0]        op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      logic [DATA_W-1:0] r;
      r = '0;
      case (op)
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_MUL: begin
`ifdef STACK_CPU_MUL_EN
            r = a * b;
`else
            r = '0;
`endif
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DCW-1:0]      dcnt_q, dcnt_d;
   logic [CCW-1:0]      ccnt_q, ccnt_d;
   logic [7:0]          op_q, op_d;
   logic                print_valid_q, print_valid_d;
   logic [DATA_W-1:0]   print_s1_q, print_s1_d;
   logic [DATA_W-1:0]   print_s0_q, print_s0_d;
   logic                halted_q, halted_d;
   logic                fault_q, fault_d;
   logic [2:0]          fcode_q, fcode_d;

   // Stack storage; contents deliberately survive reset.
   logic [DATA_W-1:0]   dmem [DSTACK_DEPTH];
   logic [ADDR_W-1:0]   cmem [CSTACK_DEPTH];

   logic                dwe;
   logic [DPW-1:0]      dwaddr;
   logic [DATA_W-1:0]   dwdata;
   logic                cwe;
   logic [CPW-1:0]      cwaddr;
   logic [ADDR_W-1:0]   cwdata;

   logic [DPW-1:0]      s0_idx, s1_idx, push_idx;
   logic [DATA_W-1:0]   s0, s1;
   logic [ADDR_W-1:0]   cs_top;

   logic signed [6:0]   imm7;
   logic signed [7:0]   off8;
   logic [ADDR_W-1:0]   pc_inc, br_target;

   logic [1:0]          dneed;
   logic                dgrow, cpush, cpop, illegal;
   logic [2:0]          exec_fcode;

   // Top entries sit just below the occupancy count.
   assign s0_idx   = DPW'(dcnt_q - DCW'(1));
   assign s1_idx   = DPW'(dcnt_q - DCW'(2));
   assign push_idx = dcnt_q[DPW-1:0];
   assign s0       = dmem[s0_idx];
   assign s1       = dmem[s1_idx];
   assign cs_top   = cmem[CPW'(ccnt_q - CCW'(1))];

   assign imm7      = code_data[6:0];
   assign off8      = code_data;
   assign pc_inc    = pc_q + ADDR_W'(1);
   // In EXEC2 pc already points at the offset byte, so +1 gives opcode+2.
   assign br_target = pc_q + ADDR_W'(1) + ADDR_W'(off8);

   // Opcode requirements. All faults, including those of two-byte ops, are
   // resolved in EXEC so a faulting instruction never advances pc.
   always_comb begin
      dneed   = 2'd0;
      dgrow   = 1'b0;
      cpush   = 1'b0;
      cpop    = 1'b0;
      illegal = 1'b0;
      if (code_data[7]) begin
         dgrow = 1'b1;
      end else begin
         case (code_data)
            OP_NOP, OP_JMP, OP_HALT: dneed = 2'd0;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_PRINT: dneed = 2'd2;
            OP_MUL: begin
               if (MUL_EN) dneed = 2'd2;
               else        illegal = 1'b1;
            end
            OP_DUP: begin
               dneed = 2'd1;
               dgrow = 1'b1;
            end
            OP_DROP, OP_JZ: dneed = 2'd1;
            OP_CALL: cpush = 1'b1;
            OP_RET:  cpop  = 1'b1;
            default: illegal = 1'b1;
         endcase
      end

      if (illegal)                               exec_fcode = F_ILL;
      else if (dcnt_q < DCW'(dneed))             exec_fcode = F_DUNF;
      else if (dgrow && (dcnt_q == DFULL))       exec_fcode = F_DOVF;
      else if (cpush && (ccnt_q == CFULL))       exec_fcode = F_COVF;
      else if (cpop && (ccnt_q == CCW'(0)))      exec_fcode = F_CUNF;
      else                                       exec_fcode = F_NONE;
   end

   // Next-state and datapath control.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      dcnt_d        = dcnt_q;
      ccnt_d        = ccnt_q;
      op_d          = op_q;
      print_valid_d = 1'b0;
      print_s1_d    = print_s1_q;
      print_s0_d    = print_s0_q;
      halted_d      = halted_q;
      fault_d       = fault_q;
      fcode_d       = fcode_q;
      dwe           = 1'b0;
      dwaddr        = push_idx;
      dwdata        = s0;
      cwe           = 1'b0;
      cwaddr        = ccnt_q[CPW-1:0];
      cwdata        = pc_inc;

      case (state_q)
         S_FETCH: begin
            if (run) state_d = S_EXEC;
         end

         S_EXEC: begin
            if (exec_fcode != F_NONE) begin
               fault_d  = 1'b1;
               fcode_d  = exec_fcode;
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else begin
               pc_d    = pc_inc;
               state_d = S_FETCH;
               if (code_data[7]) begin
                  dwe    = 1'b1;
                  dwdata = DATA_W'(imm7);
                  dcnt_d = dcnt_q + DCW'(1);
               end else begin
                  case (code_data)
                     OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL: begin
                        dwe    = 1'b1;
                        dwaddr = s1_idx;
                        dwdata = alu(code_data, s1, s0);
                        dcnt_d = dcnt_q - DCW'(1);
                     end
                     OP_DUP: begin
                        dwe    = 1'b1;
                        dcnt_d = dcnt_q + DCW'(1);
                     end
                     OP_DROP: dcnt_d = dcnt_q - DCW'(1);
                     OP_JMP, OP_JZ, OP_CALL: begin
                        op_d    = code_data;
                        state_d = S_FETCH2;
                     end
                     OP_RET: begin
                        pc_d   = cs_top;
                        ccnt_d = ccnt_q - CCW'(1);
                     end
                     OP_PRINT: begin
                        print_valid_d = 1'b1;
                        print_s1_d    = s1;
                        print_s0_d    = s0;
                     end
                     OP_HALT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                     end
                     default: state_d = S_FETCH;
                  endcase
               end
            end
         end

         S_FETCH2: state_d = S_EXEC2;

         S_EXEC2: begin
            state_d = S_FETCH;
            case (op_q)
               OP_JMP: pc_d = br_target;
               OP_JZ: begin
                  dcnt_d = dcnt_q - DCW'(1);
                  pc_d   = (s0 == '0) ? br_target : pc_inc;
               end
               OP_CALL: begin
                  cwe    = 1'b1;
                  ccnt_d = ccnt_q + CCW'(1);
                  pc_d   = br_target;
               end
               default: pc_d = pc_inc;
            endcase
         end

         S_HALT: state_d = S_HALT;

         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_FETCH;
         pc_q          <= '0;
         dcnt_q        <= '0;
         ccnt_q        <= '0;
         op_q          <= '0;
         print_valid_q <= 1'b0;
         print_s1_q    <= '0;
         print_s0_q    <= '0;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
         fcode_q       <= F_NONE;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         dcnt_q        <= dcnt_d;
         ccnt_q        <= ccnt_d;
         op_q          <= op_d;
         print_valid_q <= print_valid_d;
         print_s1_q    <= print_s1_d;
         print_s0_q    <= print_s0_d;
         halted_q      <= halted_d;
         fault_q       <= fault_d;
         fcode_q       <= fcode_d;
      end
   end

   always_ff @(posedge clock) begin
      if (dwe) dmem[dwaddr] <= dwdata;
      if (cwe) cmem[cwaddr] <= cwdata;
   end

   assign code_addr   = pc_q;
   assign print_valid = print_valid_q;
   assign print_s1    = print_s1_q;
   assign print_s0    = print_s0_q;
   assign halted      = halted_q;
   assign fault       = fault_q;
   assign fault_code  = fcode_q;
   assign depth       = dcnt_q;

endmodule

// File: tb/tb_stack_cpu_core.sv
// ---------------------------------------------------------------------------
// tb_stack_cpu_core
//
// Directed bench for stack_cpu_core with default parameters. A behavioural
// synchronous ROM with one cycle of latency feeds the core. Each program is
// loaded while reset is held and then run until the core halts. Define
// STACK_CPU_MUL_EN for both files to exercise the MUL variant.
// ---------------------------------------------------------------------------
module tb_stack_cpu_core;

   logic        clock;
   logic        reset;
   logic        run;
   logic [11:0] code_addr;
   logic [7:0]  code_data;
   logic        print_valid;
   logic [15:0] print_s1;
   logic [15:0] print_s0;
   logic        halted;
   logic        fault;
   logic [2:0]  fault_code;
   logic [3:0]  depth;

   logic [7:0]  rom [0:4095];

   int          n_asrt;
   int          n_fail;
   int          pcount;
   logic [15:0] last_s1;
   logic [15:0] last_s0;

   stack_cpu_core #(
      .DATA_W       (16),
      .ADDR_W       (12),
      .DSTACK_DEPTH (8),
      .CSTACK_DEPTH (8)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .run         (run),
      .code_addr   (code_addr),
      .code_data   (code_data),
      .print_valid (print_valid),
      .print_s1    (print_s1),
      .print_s0    (print_s0),
      .halted      (halted),
      .fault       (fault),
      .fault_code  (fault_code),
      .depth       (depth)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) code_data <= rom[code_addr];

   // Count cycles in which print_valid is high and remember the last values.
   always @(negedge clock) begin
      if (reset) begin
         pcount  = 0;
         last_s1 = '0;
         last_s0 = '0;
      end else if (print_valid) begin
         pcount  = pcount + 1;
         last_s1 = print_s1;
         last_s0 = print_s0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold reset and blank the ROM; caller then writes the program.
   task automatic begin_prog();
      reset = 1'b1;
      run   = 1'b0;
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      repeat (2) @(negedge clock);
   endtask

   task automatic go();
      @(negedge clock);
      reset = 1'b0;
      run   = 1'b1;
   endtask

   task automatic wait_halt(input string tag, input int maxc);
      int c;
      c = 0;
      while (!halted && c < maxc) begin
         @(negedge clock);
         c++;
      end
      chk(tag, {31'd0, halted}, 32'd1);
   endtask

   initial begin
      n_asrt = 0;
      n_fail = 0;
      reset  = 1'b1;
      run    = 1'b0;

      // Reset state
      begin_prog();
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_fcode", {29'd0, fault_code}, 32'd0);
      chk("rst_depth", {28'd0, depth}, 32'd0);
      chk("rst_pvalid", {31'd0, print_valid}, 32'd0);
      chk("rst_addr", {20'd0, code_addr}, 32'd0);

      // PUSH 0, PUSH 2, PUSH 3, ADD, PRINT, HALT
      begin_prog();
      rom[0] = 8'h80; rom[1] = 8'h82; rom[2] = 8'h83;
      rom[3] = 8'h20; rom[4] = 8'h41; rom[5] = 8'h44;
      go();
      wait_halt("add_halt", 200);
      chk("add_pcount", pcount, 32'd1);
      chk("add_s1", {16'd0, last_s1}, 32'd0);
      chk("add_s0", {16'd0, last_s0}, 32'd5);
      chk("add_fault", {31'd0, fault}, 32'd0);
      chk("add_depth", {28'd0, depth}, 32'd2);
      chk("add_pc", {20'd0, code_addr}, 32'd6);

      // PUSH 2, PUSH 3, ADD, PRINT: PRINT at depth 1 underflows
      begin_prog();
      rom[0] = 8'h82; rom[1] = 8'h83; rom[2] = 8'h20;
      rom[3] = 8'h41; rom[4] = 8'h44;
      go();
      wait_halt("prunf_halt", 200);
      chk("prunf_pcount", pcount, 32'd0);
      chk("prunf_fault", {31'd0, fault}, 32'd1);
      chk("prunf_fcode", {29'd0, fault_code}, 32'd2);
      chk("prunf_depth", {28'd0, depth}, 32'd1);
      chk("prunf_pc", {20'd0, code_addr}, 32'd3);

      // PUSH -1, PUSH 1, SUB, DUP, PRINT, DROP, HALT
      begin_prog();
      rom[0] = 8'hFF; rom[1] = 8'h81; rom[2] = 8'h21; rom[3] = 8'h24;
      rom[4] = 8'h41; rom[5] = 8'h26; rom[6] = 8'h44;
      go();
      wait_halt("sub_halt", 200);
      chk("sub_s0", {16'd0, last_s0}, 32'h0000FFFE);
      chk("sub_s1", {16'd0, last_s1}, 32'h0000FFFE);
      chk("sub_depth", {28'd0, depth}, 32'd1);
      chk("sub_fault", {31'd0, fault}, 32'd0);
      chk("sub_pc", {20'd0, code_addr}, 32'd7);

      // JZ not taken
      begin_prog();
      rom[0] = 8'h81; rom[1] = 8'h31; rom[2] = 8'h02;
      rom[3] = 8'h44; rom[4] = 8'h00; rom[5] = 8'h44;
      go();
      wait_halt("jzn_halt", 200);
      chk("jzn_pc", {20'd0, code_addr}, 32'd4);
      chk("jzn_depth", {28'd0, depth}, 32'd0);
      chk("jzn_fault", {31'd0, fault}, 32'd0);

      // JZ taken
      begin_prog();
      rom[0] = 8'h80; rom[1] = 8'h31; rom[2] = 8'h02;
      rom[3] = 8'h44; rom[4] = 8'h00; rom[5] = 8'h44;
      go();
      wait_halt("jzt_halt", 200);
      chk("jzt_pc", {20'd0, code_addr}, 32'd6);
      chk("jzt_depth", {28'd0, depth}, 32'd0);

      // Nine pushes overflow an 8-deep stack
      begin_prog();
      for (int i = 0; i < 9; i++) rom[i] = 8'h81;
      go();
      wait_halt("dovf_halt", 200);
      chk("dovf_fault", {31'd0, fault}, 32'd1);
      chk("dovf_fcode", {29'd0, fault_code}, 32'd1);
      chk("dovf_depth", {28'd0, depth}, 32'd8);
      chk("dovf_pc", {20'd0, code_addr}, 32'd8);

      // Lone ADD underflows
      begin_prog();
      rom[0] = 8'h20;
      go();
      wait_halt("dunf_halt", 50);
      chk("dunf_fcode", {29'd0, fault_code}, 32'd2);
      chk("dunf_depth", {28'd0, depth}, 32'd0);
      chk("dunf_pc", {20'd0, code_addr}, 32'd0);

      // CALL +3 into subroutine PUSH 2, RET; then PRINT, HALT
      begin_prog();
      rom[0] = 8'h80; rom[1] = 8'h32; rom[2] = 8'h03; rom[3] = 8'h41;
      rom[4] = 8'h44; rom[5] = 8'h00; rom[6] = 8'h82; rom[7] = 8'h33;
      go();
      wait_halt("call_halt", 200);
      chk("call_pcount", pcount, 32'd1);
      chk("call_s1", {16'd0, last_s1}, 32'd0);
      chk("call_s0", {16'd0, last_s0}, 32'd2);
      chk("call_fault", {31'd0, fault}, 32'd0);
      chk("call_pc", {20'd0, code_addr}, 32'd5);

      // RET with empty call stack
      begin_prog();
      rom[0] = 8'h33;
      go();
      wait_halt("cunf_halt", 50);
      chk("cunf_fcode", {29'd0, fault_code}, 32'd4);
      chk("cunf_pc", {20'd0, code_addr}, 32'd0);

      // CALL -2 to itself: ninth CALL overflows the call stack
      begin_prog();
      rom[0] = 8'h32; rom[1] = 8'hFE;
      go();
      wait_halt("covf_halt", 200);
      chk("covf_fcode", {29'd0, fault_code}, 32'd3);
      chk("covf_pc", {20'd0, code_addr}, 32'd0);

      // PUSH 3, PUSH 3, MUL, DUP, PRINT, HALT
      begin_prog();
      rom[0] = 8'h83; rom[1] = 8'h83; rom[2] = 8'h25;
      rom[3] = 8'h24; rom[4] = 8'h41; rom[5] = 8'h44;
      go();
      wait_halt("mul_halt", 200);
`ifdef STACK_CPU_MUL_EN
      chk("mul_fault", {31'd0, fault}, 32'd0);
      chk("mul_s0", {16'd0, last_s0}, 32'd9);
      chk("mul_s1", {16'd0, last_s1}, 32'd9);
      chk("mul_depth", {28'd0, depth}, 32'd2);
      chk("mul_pc", {20'd0, code_addr}, 32'd6);
`else
      chk("mul_fcode", {29'd0, fault_code}, 32'd5);
      chk("mul_depth", {28'd0, depth}, 32'd2);
      chk("mul_pc", {20'd0, code_addr}, 32'd2);
      chk("mul_pcount", pcount, 32'd0);
`endif

      // Other undefined opcode
      begin_prog();
      rom[0] = 8'h27;
      go();
      wait_halt("ill_halt", 50);
      chk("ill_fcode", {29'd0, fault_code}, 32'd5);

      // Reset during the EXEC cycle of a JMP, then stall with run=0
      begin_prog();
      rom[0] = 8'h30; rom[1] = 8'h05; rom[7] = 8'h81; rom[8] = 8'h44;
      go();
      @(negedge clock);
      reset = 1'b1;
      run   = 1'b0;
      #1;
      chk("midrst_addr", {20'd0, code_addr}, 32'd0);
      chk("midrst_halted", {31'd0, halted}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("stall_addr", {20'd0, code_addr}, 32'd0);
         chk("stall_depth", {28'd0, depth}, 32'd0);
      end
      run = 1'b1;
      wait_halt("resume_halt", 200);
      chk("resume_pc", {20'd0, code_addr}, 32'd9);
      chk("resume_depth", {28'd0, depth}, 32'd1);
      chk("resume_fault", {31'd0, fault}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
